cpu_muldiv: RTL

CPU-side hardware multiply/divide unit on Bus-A. It decodes Bus-A register operations (`a_op_type`), latches operands, and runs an iterative unsigned 8×8 multiply or 16÷8 divide paced by CPU cycles. It returns RDDIV/RDMPY read data to the Bus-A read mux, which selects it under read target `A_RT_MD`.

---
 rtl/bus_pkg.sv | 33 +++
 rtl/cpu_muldiv_if.sv | 22 ++
 rtl/cpu_muldiv_div_step.sv | 36 +++
 rtl/cpu_muldiv.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// ---------------------------------------------------------------------------
// bus_pkg
// Shared Bus-A definitions used by the CPU-side register blocks.
//   a_op_type          decoded Bus-A register operation
//   muldiv_state_type  sequencer state of the multiply/divide unit
//   MUL_STEPS          arithmetic steps for an 8x8 multiply
//   DIV_STEPS          arithmetic steps for a 16/8 divide
// ---------------------------------------------------------------------------
package bus_pkg;

    typedef enum logic [3:0] {
        A_NOP,
        A_WRMPYA,
        A_WRMPYB,
        A_WRDIVL,
        A_WRDIVH,
        A_WRDIVB,
        A_RDMPYL,
        A_RDMPYH,
        A_RDDIVL,
        A_RDDIVH
    } a_op_type;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV
    } muldiv_state_type;

    localparam int MUL_STEPS = 8;
    localparam int DIV_STEPS = 16;

endpackage

// File: rtl/cpu_muldiv_if.sv
// ---------------------------------------------------------------------------
// cpu_muldiv_if
// Bus-A register access bundle for the multiply/divide unit.
//   a_op   decoded operation (master -> slave)
//   a_we   one-clk write strobe (master -> slave)
//   wdata  write data (master -> slave)
//   rdata  read data for the RDDIV/RDMPY registers (slave -> master)
//   busy   operation in progress (slave -> master)
// ---------------------------------------------------------------------------
interface cpu_muldiv_if;
    import bus_pkg::*;

    a_op_type    a_op;
    logic        a_we;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic        busy;

    modport master (output a_op, output a_we, output wdata, input rdata, input busy);
    modport slave  (input a_op, input a_we, input wdata, output rdata, output busy);

endinterface

// File: rtl/cpu_muldiv_div_step.sv
// ---------------------------------------------------------------------------
// muldiv_div_step
// One combinational restoring-division step. Step k tests quotient bit
// (15-k) by comparing the partial remainder against the divisor shifted
// into that bit position.
//   r       partial remainder in
//   d       divisor
//   k       step index 0..15
//   q       partial quotient in
//   r_next  partial remainder out
//   q_next  partial quotient out (q shifted left, new bit in LSB)
// ---------------------------------------------------------------------------
module muldiv_div_step (
    input  logic [15:0] r,
    input  logic [7:0]  d,
    input  logic [3:0]  k,
    input  logic [15:0] q,
    output logic [15:0] r_next,
    output logic [15:0] q_next
);

    logic [22:0] d_shift;
    logic        ge;

    // The shifted divisor needs 23 bits so high divisor bits are never lost;
    // whenever r >= d_shift the upper 7 bits are zero, so the 16-bit subtract
    // is exact. A zero divisor always compares true, giving an all-ones
    // quotient and an untouched remainder.
    always_comb begin
        d_shift = {15'b0, d} << (4'd15 - k);
        ge      = ({7'b0, r} >= d_shift);
        r_next  = ge ? (r - d_shift[15:0]) : r;
        q_next  = {q[14:0], ge};
    end

endmodule

// File: rtl/cpu_muldiv.sv
// ---------------------------------------------------------------------------
// cpu_muldiv
// CPU-side unsigned 8x8 multiply / 16/8 divide unit on Bus-A. Operand writes
// land in latches; a WRMPYB or WRDIVB write copies them into shadow registers
// and starts an iterative operation advanced one step per cpu_cycle_ce.
//   clk           system clock
//   rst_n         synchronous active-low reset
//   cpu_cycle_ce  one-clk pulse per CPU cycle, advances one step
//   bus           cpu_muldiv_if.slave (a_op, a_we, wdata, rdata, busy)
// Build option MULDIV_INSTANT_EN: results are written at the start edge,
// the sequencer never leaves IDLE and busy stays 0.
// ---------------------------------------------------------------------------
module cpu_muldiv
    import bus_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_cycle_ce,
    cpu_muldiv_if.slave bus
);

    muldiv_state_type state, state_nx;
    logic [3:0]  cnt, cnt_nx;
    logic [7:0]  mpya, mpya_nx;
    logic [15:0] wrdiv, wrdiv_nx;
    logic [15:0] rddiv, rddiv_nx;
    logic [15:0] rdmpy, rdmpy_nx;
    logic [15:0] ma, ma_nx;
    logic [7:0]  mb, mb_nx;
    logic [15:0] r, r_nx;
    logic [7:0]  d, d_nx;
    logic [15:0] step_r, step_q;
    logic        start_mul, start_div;

    assign start_mul = bus.a_we && (bus.a_op == A_WRMPYB);
    assign start_div = bus.a_we && (bus.a_op == A_WRDIVB);

`ifdef MULDIV_INSTANT_EN
    // Full 16-step divide unrolled over the freshly written divisor.
    logic [15:0] chain_r [0:DIV_STEPS];
    logic [15:0] chain_q [0:DIV_STEPS];

    assign chain_r[0] = wrdiv;
    assign chain_q[0] = 16'h0000;

    for (genvar i = 0; i < DIV_STEPS; i++) begin : g_div
        muldiv_div_step u_step (
            .r      (chain_r[i]),
            .d      (bus.wdata),
            .k      (4'(i)),
            .q      (chain_q[i]),
            .r_next (chain_r[i+1]),
            .q_next (chain_q[i+1])
        );
    end

    assign step_r = chain_r[DIV_STEPS];
    assign step_q = chain_q[DIV_STEPS];
`else
    muldiv_div_step u_step (
        .r      (r),
        .d      (d),
        .k      (cnt),
        .q      (rddiv),
        .r_next (step_r),
        .q_next (step_q)
    );
`endif

    // Next-state and datapath. A start write always takes priority over a
    // coincident step, which is what gives abort-and-restart semantics.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        mpya_nx  = mpya;
        wrdiv_nx = wrdiv;
        rddiv_nx = rddiv;
        rdmpy_nx = rdmpy;
        ma_nx    = ma;
        mb_nx    = mb;
        r_nx     = r;
        d_nx     = d;

        if (bus.a_we) begin
            case (bus.a_op)
                A_WRMPYA: mpya_nx         = bus.wdata;
                A_WRDIVL: wrdiv_nx[7:0]   = bus.wdata;
                A_WRDIVH: wrdiv_nx[15:8]  = bus.wdata;
                default:  ;
            endcase
        end

        if (start_mul) begin
            rddiv_nx = {8'h00, bus.wdata};
`ifdef MULDIV_INSTANT_EN
            rdmpy_nx = {8'h00, mpya} * {8'h00, bus.wdata};
`else
            rdmpy_nx = 16'h0000;
            ma_nx    = {8'h00, mpya};
            mb_nx    = bus.wdata;
            state_nx = MUL;
            cnt_nx   = 4'd0;
`endif
        end else if (start_div) begin
`ifdef MULDIV_INSTANT_EN
            rddiv_nx = step_q;
            rdmpy_nx = step_r;
`else
            r_nx     = wrdiv;
            d_nx     = bus.wdata;
            rddiv_nx = 16'h0000;
            state_nx = DIV;
            cnt_nx   = 4'd0;
`endif
        end else if (cpu_cycle_ce) begin
            case (state)
                MUL: begin
                    if (mb[0]) begin
                        rdmpy_nx = rdmpy + ma;
                    end
                    ma_nx  = ma << 1;
                    mb_nx  = mb >> 1;
                    cnt_nx = cnt + 4'd1;
                    if (cnt == 4'(MUL_STEPS - 1)) begin
                        state_nx = IDLE;
                    end
                end
                DIV: begin
                    r_nx     = step_r;
                    rddiv_nx = step_q;
                    rdmpy_nx = step_r;
                    cnt_nx   = cnt + 4'd1;
                    if (cnt == 4'(DIV_STEPS - 1)) begin
                        state_nx = IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= 4'd0;
            mpya  <= 8'hFF;
            wrdiv <= 16'hFFFF;
            rddiv <= 16'h0000;
            rdmpy <= 16'h0000;
            ma    <= 16'h0000;
            mb    <= 8'h00;
            r     <= 16'h0000;
            d     <= 8'h00;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            mpya  <= mpya_nx;
            wrdiv <= wrdiv_nx;
            rddiv <= rddiv_nx;
            rdmpy <= rdmpy_nx;
            ma    <= ma_nx;
            mb    <= mb_nx;
            r     <= r_nx;
            d     <= d_nx;
        end
    end

    // Read mux is combinational from the current operation code.
    always_comb begin
        bus.rdata = 8'h00;
        case (bus.a_op)
            A_RDMPYL: bus.rdata = rdmpy[7:0];
            A_RDMPYH: bus.rdata = rdmpy[15:8];
            A_RDDIVL: bus.rdata = rddiv[7:0];
            A_RDDIVH: bus.rdata = rddiv[15:8];
            default:  ;
        endcase
    end

    assign bus.busy = (state != IDLE);

endmodule
